l1_port_arbiter: RTL
====================

Name: l1_port_arbiter

Overview:
- Shares one single-ported, synchronous-read L1 SRAM between the core's instruction-fetch port and data port.
- Replaces the ideal 2-ported unified L1 in area-realistic builds.
- Produces the imem/dmem wait signals the 5-stage core already stalls on.
- Data has priority; a starvation counter guarantees fetch progress.

Parameters:
- RAM_WORDS, 16384, SRAM depth in 32-bit words (64 KB).
- AW, $clog2(RAM_WORDS), SRAM word-address width (derived).
- STARVE_LIMIT, 4, consecutive lost arbitration cycles after which fetch wins over data.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held stable with i_addr while i_wait=1.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_instn  out  32  fetched word; valid when i_req=1 and i_wait=0, else 0.
- i_wait  out  1  fetch stall.
- d_req  in  1  data access request (load or store); held stable with the d_* inputs while d_wait=1.
- d_we  in  1  store when 1, load when 0; qualified by d_req.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wd  in  32  store data.
- d_mask  in  4  store byte enables.
- d_rd  out  32  load data; valid when d_req=1, d_we=0 and d_wait=0, else 0.
- d_wait  out  1  data stall.
- sram_en  out  1  SRAM access this cycle.
- sram_we  out  1  SRAM write.
- sram_addr  out  AW  word address (byte addr [AW+1:2]).
- sram_be  out  4  byte enables (d_mask for writes, 4'hF for reads).
- sram_wd  out  32  write data.
- sram_rd  in  32  read data, valid the cycle after a read issue.

Behaviour:
- Access timing: every access is issued in cycle t (sram_en=1) and completes in t+1.
  - Requester's wait is 1 in t and 0 in t+1.
  - Read data is taken combinationally from sram_rd in t+1.
  - Stores write in t; completion in t+1 is uniform with loads.
- State register done_q ∈ {DONE_NONE, DONE_I, DONE_D} names the port completing this cycle.
- Eligibility: a port is eligible in cycle c if its req=1 and done_q ≠ that port.
  - This prevents re-issuing the access that is completing.
- Arbitration among eligible ports:
  - Only one eligible → grant it.
  - Both eligible → grant D unless starve_q == STARVE_LIMIT, then grant I.
  - done_q_next = granted port, or DONE_NONE if no grant.
- Throughput: alternating I/D gives one access per cycle; a single port achieves at most one access per 2 cycles.
- Wait outputs:
  - i_wait = i_req & (done_q ≠ DONE_I).
  - d_wait = d_req & (done_q ≠ DONE_D).
  - When req=0, wait=0.
- Dropped requests (e.g. fetch flush): if req is 0 in the completion cycle, the read result is discarded, output is 0, and no retry is issued. A completed store is never undone.
- Starvation counter starve_q, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, each cycle I is eligible and D is granted.
  - Clears on an I grant or when i_req=0.
- Reset values: done_q=DONE_NONE, starve_q=0, sram_en=0, sram_we=0, i_wait=0 and d_wait=0 with reqs low, i_instn=0, d_rd=0.
- Reset mid-operation: in-flight read is dropped; no completion appears after reset deasserts; a store issued before reset stays written.
- sram_addr, sram_be, sram_wd are combinational from the granted port's inputs and don't-care when sram_en=0; bench checks them only when sram_en=1.
- Address truncation: bits above AW+1 are ignored; no range error is signalled.

Decomposition:
- Shared package l1_arb_pkg:
  - typedef enum logic [1:0] {DONE_NONE, DONE_I, DONE_D} done_t;
  - localparam WORD_BYTES=4.
- No child module.
- Sibling sub-module l1_sp_sram: 1-port, byte-enable, 1-cycle read, +EXEC preload; it is the natural partner instantiated next to the arbiter in the L1 wrapper.

Test Plan:
- Reset: hold reset 3 cycles with both reqs high → sram_en=0, i_instn=0, d_rd=0, done_q=DONE_NONE; first grant occurs the cycle after reset drops.
- Lone fetch: preload word 0x10 = 0x00500093; i_req=1, i_addr=0x40 → cycle t sram_addr=0x10, i_wait=1; t+1 i_wait=0, i_instn=0x00500093.
- Collision: i_req and d_req (load 0x80) both rise at t → D issued at t, I at t+1; d_wait=0 at t+1, i_wait=0 at t+2; sram_en high at t and t+1.
- Masked store then load: d_we=1, d_addr=0x100, d_wd=0xAABBCCDD, d_mask=4'b0101 over word preloaded with 0x11223344 → subsequent load returns 0x11BB33DD.
- Starvation: d_req held high with new addresses every completion, i_req high → I granted within STARVE_LIMIT+2 = 6 cycles; starve_q returns to 0 after the I grant.
- Flush and reset mid-access: i_req drops in the completion cycle → i_instn=0, no reissue; separately, assert reset in a load's issue cycle → no d_wait=0 completion pulse after reset, and next load reissues normally.

Source files
------------

// File: rtl/l1_arb_pkg.sv
// Shared types for the L1 single-port arbiter.
//   done_t     : which port completes its SRAM access in the current cycle
//   WORD_BYTES : bytes per SRAM word (width of byte-enable buses)
package l1_arb_pkg;

  typedef enum logic [1:0] {
    DONE_NONE = 2'd0,
    DONE_I    = 2'd1,
    DONE_D    = 2'd2
  } done_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/l1_port_arbiter.sv
// Shares one single-ported, synchronous-read SRAM between the core's fetch
// port (i_*) and data port (d_*). An access issues in cycle t (sram_en=1)
// and completes in t+1, where read data is forwarded combinationally from
// sram_rd. Data wins collisions unless fetch has lost STARVE_LIMIT times in
// a row.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   i_req/i_addr           fetch request and byte address
//   i_instn/i_wait         fetched word (0 unless completing) and fetch stall
//   d_req/d_we/d_addr      data request, store flag, byte address
//   d_wd/d_mask            store data and byte enables
//   d_rd/d_wait            load data (0 unless completing) and data stall
//   sram_en/sram_we        SRAM access / write strobe
//   sram_addr/be/wd        SRAM word address, byte enables, write data
//   sram_rd                SRAM read data, valid the cycle after a read issue
module l1_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter  int unsigned RAM_WORDS    = 16384,
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned AW           = $clog2(RAM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_instn,
  output logic                  i_wait,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wd,
  input  logic [WORD_BYTES-1:0] d_mask,
  output logic [31:0]           d_rd,
  output logic                  d_wait,

  output logic                  sram_en,
  output logic                  sram_we,
  output logic [AW-1:0]         sram_addr,
  output logic [WORD_BYTES-1:0] sram_be,
  output logic [31:0]           sram_wd,
  input  logic [31:0]           sram_rd
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  done_t         done_q, done_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          i_elig_c, d_elig_c;
  logic          grant_i_c, grant_d_c;

  // Byte-offset bits and address bits above the SRAM range are dropped.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0],
                              d_addr[31:AW+2], d_addr[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= DONE_NONE;
      starve_q <= '0;
    end else begin
      done_q   <= done_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration and next state.
  always_comb begin
    i_elig_c  = 1'b0;
    d_elig_c  = 1'b0;
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    done_d    = DONE_NONE;
    starve_d  = starve_q;

    // A port is not eligible in the cycle its own access is completing,
    // otherwise the same request would be issued twice.
    i_elig_c = i_req && (done_q != DONE_I);
    d_elig_c = d_req && (done_q != DONE_D);

    // No issue while in reset so nothing is written or left in flight.
    if (!reset) begin
      grant_i_c = i_elig_c && (!d_elig_c || (starve_q == STARVE_MAX));
      grant_d_c = d_elig_c && !grant_i_c;
    end

    if (grant_i_c) begin
      done_d = DONE_I;
    end else if (grant_d_c) begin
      done_d = DONE_D;
    end

    // Count consecutive fetch losses; saturate at the limit.
    if (!i_req || grant_i_c) begin
      starve_d = '0;
    end else if (i_elig_c && grant_d_c && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Outputs.
  always_comb begin
    sram_en   = grant_i_c || grant_d_c;
    sram_we   = grant_d_c && d_we;
    sram_addr = i_addr[AW+1:2];
    sram_be   = {WORD_BYTES{1'b1}};
    sram_wd   = d_wd;
    i_wait    = i_req && (done_q != DONE_I);
    d_wait    = d_req && (done_q != DONE_D);
    i_instn   = '0;
    d_rd      = '0;

    if (grant_d_c) begin
      sram_addr = d_addr[AW+1:2];
      if (d_we) begin
        sram_be = d_mask;
      end
    end

    // A request dropped in its completion cycle sees no data.
    if (i_req && (done_q == DONE_I)) begin
      i_instn = sram_rd;
    end
    if (d_req && !d_we && (done_q == DONE_D)) begin
      d_rd = sram_rd;
    end
  end

endmodule
